// File: rtl/ahb_copy_master.sv
// ahb_copy_master
// AHB-Lite initiator that copies a block of 32-bit words from a source
// address to a destination address. Each word is one single NONSEQ read
// followed by one single NONSEQ write; wait states are honoured via HREADY.
//
// Ports:
//   HCLK, HRESETn         bus clock, async active-low reset
//   start                 one-cycle request, sampled only while idle
//   src_addr, dst_addr    byte addresses (bits [1:0] forced to 0)
//   len                   word count (0 completes with no bus traffic)
//   busy                  high in every state except IDLE
//   done                  one-cycle completion pulse
//   HADDR/HTRANS/HWRITE/HSIZE/HWDATA  AHB-Lite master outputs
//   HRDATA, HREADY        AHB-Lite slave responses

`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module ahb_copy_master #(
    parameter int LEN_W = 16
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       start,
    input  logic [`AHB_ADDR_WIDTH-1:0] src_addr,
    input  logic [`AHB_ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_W-1:0]           len,
    output logic                       busy,
    output logic                       done,
    output logic [`AHB_ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]                 HTRANS,
    output logic                       HWRITE,
    output logic [2:0]                 HSIZE,
    output logic [`AHB_DATA_WIDTH-1:0] HWDATA,
    input  logic [`AHB_DATA_WIDTH-1:0] HRDATA,
    input  logic                       HREADY
);

    localparam int AW = `AHB_ADDR_WIDTH;
    localparam int DW = `AHB_DATA_WIDTH;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR_A,
        S_WR_D,
        S_DONE
    } state_e;

    state_e            state_q,   state_d;
    logic [AW-1:0]     src_ptr_q, src_ptr_d;
    logic [AW-1:0]     dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0]  rem_q,     rem_d;
    logic [DW-1:0]     buf_q,     buf_d;

    logic [AW-1:0]     haddr_q,   haddr_d;
    logic [1:0]        htrans_q,  htrans_d;
    logic              hwrite_q,  hwrite_d;
    logic [DW-1:0]     hwdata_q,  hwdata_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;

    // Next-state and datapath. Bus outputs are derived from the *next*
    // state so they can be registered and still line up with the state
    // they belong to; nothing reaches an output from HREADY/HRDATA without
    // passing through a flop.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        buf_d     = buf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_ptr_d = {src_addr[AW-1:2], 2'b00};
                    dst_ptr_d = {dst_addr[AW-1:2], 2'b00};
                    rem_d     = len;
                    state_d   = (len != '0) ? S_RD_A : S_DONE;
                end
            end
            S_RD_A: begin
                if (HREADY) state_d = S_RD_D;
            end
            S_RD_D: begin
                if (HREADY) begin
                    buf_d   = HRDATA;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: begin
                if (HREADY) state_d = S_WR_D;
            end
            S_WR_D: begin
                if (HREADY) begin
                    rem_d     = rem_q - LEN_W'(1);
                    // Pointers wrap naturally at the top of the address space.
                    src_ptr_d = src_ptr_q + AW'(4);
                    dst_ptr_d = dst_ptr_q + AW'(4);
                    state_d   = (rem_q == LEN_W'(1)) ? S_DONE : S_RD_A;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        htrans_d = ((state_d == S_RD_A) || (state_d == S_WR_A)) ? TR_NONSEQ : TR_IDLE;
        hwrite_d = (state_d == S_WR_A) || (state_d == S_WR_D);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);

        // HADDR only moves when a new address phase starts; it holds through
        // data phases and idle so it never glitches during a stall.
        haddr_d = haddr_q;
        if (state_d == S_RD_A)      haddr_d = src_ptr_d;
        else if (state_d == S_WR_A) haddr_d = dst_ptr_d;

        // Write data is loaded on entry to WR_D and held until the next write.
        hwdata_d = hwdata_q;
        if ((state_d == S_WR_D) && (state_q != S_WR_D)) hwdata_d = buf_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            buf_q     <= '0;
            haddr_q   <= '0;
            htrans_q  <= TR_IDLE;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            buf_q     <= buf_d;
            haddr_q   <= haddr_d;
            htrans_q  <= htrans_d;
            hwrite_q  <= hwrite_d;
            hwdata_q  <= hwdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = 3'b010;
    assign HWDATA = hwdata_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_ahb_copy_master.sv
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module tb_ahb_copy_master;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;

    always #5 HCLK = ~HCLK;

    ahb_copy_master #(.LEN_W(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    // ---------------- slave model ----------------
    // Read data is a fixed function of address; writes are logged.
    function automatic logic [31:0] rdf(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a ^ 32'h5A5A_0000) + 32'h11;
    endfunction

    logic        dp_act, dp_wr;
    logic [31:0] dp_addr;
    int          wait_cnt;
    int          stall_n;
    logic [31:0] rd_log[$];
    logic [31:0] wa_log[$];
    logic [31:0] wd_log[$];

    assign HREADY = !(dp_act && wait_cnt != 0);

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_act   <= 1'b0;
            dp_wr    <= 1'b0;
            dp_addr  <= '0;
            wait_cnt <= 0;
            HRDATA   <= '0;
        end else begin
            if (dp_act && HREADY) begin
                if (dp_wr) begin
                    wa_log.push_back(dp_addr);
                    wd_log.push_back(HWDATA);
                end
                dp_act <= 1'b0;
            end else if (dp_act) begin
                wait_cnt <= wait_cnt - 1;
            end
            if (HTRANS == 2'b10 && HREADY) begin
                dp_act   <= 1'b1;
                dp_addr  <= HADDR;
                dp_wr    <= HWRITE;
                wait_cnt <= stall_n;
                if (!HWRITE) begin
                    HRDATA <= rdf(HADDR);
                    rd_log.push_back(HADDR);
                end
            end
        end
    end

    // ---------------- checking ----------------
    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          cyc;
        logic        busy;
        logic        done;
        logic [1:0]  htrans;
        logic        hwrite;
        logic [31:0] haddr;
        logic [31:0] hwdata;
    } vec_t;

    vec_t tr[1:12];

    // Runs one copy; cycle 0 is the start cycle, cycle c is sampled at the
    // negedge inside it.
    task automatic run_copy(input logic [31:0] src, input logic [31:0] dst,
                            input logic [15:0] l, input int stall,
                            input int restart_at, input int reset_at,
                            output int done_cyc, output int n_done, output int n_ns);
        logic        p_valid, p_hready, p_hwrite;
        logic [1:0]  p_htrans;
        logic [31:0] p_haddr, p_hwdata;
        stall_n  = stall;
        done_cyc = 0;
        n_done   = 0;
        n_ns     = 0;
        p_valid  = 1'b0;
        p_hready = 1'b1; p_hwrite = 1'b0; p_htrans = 2'b00;
        p_haddr  = '0;   p_hwdata = '0;
        @(negedge HCLK);
        src_addr = src; dst_addr = dst; len = l; start = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge HCLK);
            start = 1'b0;
            if (c == restart_at) begin
                start = 1'b1; src_addr = 32'h7000; dst_addr = 32'h8000; len = 16'd9;
            end
            if (c == reset_at) begin
                HRESETn = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_htrans", HTRANS, 2'b00);
                chk("rst_hwrite", HWRITE, 0);
                chk("rst_haddr", HADDR, 0);
                chk("rst_hwdata", HWDATA, 0);
                @(negedge HCLK);
                HRESETn = 1'b1;
                break;
            end
            if (c <= 12) begin
                tr[c].cyc = c; tr[c].busy = busy; tr[c].done = done;
                tr[c].htrans = HTRANS; tr[c].hwrite = HWRITE;
                tr[c].haddr = HADDR; tr[c].hwdata = HWDATA;
            end
            if (done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (HTRANS == 2'b10) n_ns++;
            if (p_valid && !p_hready) begin
                checks++;
                if (HADDR !== p_haddr || HWDATA !== p_hwdata ||
                    HTRANS !== p_htrans || HWRITE !== p_hwrite) begin
                    errs++;
                    $display("FAIL stall_hold c=%0d: got %h/%h expected %h/%h",
                             c, HADDR, HWDATA, p_haddr, p_hwdata);
                end
            end
            p_valid = 1'b1; p_hready = HREADY;
            p_haddr = HADDR; p_hwdata = HWDATA; p_htrans = HTRANS; p_hwrite = HWRITE;
            if (done_cyc != 0 && !busy) break;
        end
        if (reset_at == 0 && done_cyc == 0) begin
            checks++; errs++;
            $display("FAIL timeout: got no done expected done within 400 cycles");
        end
    endtask

    task automatic chk_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int l, input int nr, input int nw);
        logic [31:0] s, d;
        chk("n_reads", rd_log.size() - nr, l);
        chk("n_writes", wa_log.size() - nw, l);
        if (rd_log.size() - nr == l && wa_log.size() - nw == l) begin
            for (int k = 0; k < l; k++) begin
                s = src + 32'(4 * k);
                d = dst + 32'(4 * k);
                chk("rd_addr", rd_log[nr + k], s);
                chk("wr_addr", wa_log[nw + k], d);
                chk("wr_data", wd_log[nw + k], rdf(s));
            end
        end
    endtask

    initial begin
        vec_t vt[6];
        int   dc, nd, nns, nr, nw;

        // Expected per-cycle trace of the first copy after reset
        // (len=1, 0x100 -> 0x200, no wait states).
        vt[0] = '{1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0};
        vt[1] = '{2, 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0};
        vt[2] = '{3, 1'b1, 1'b0, 2'b10, 1'b1, 32'h200, 32'h0};
        vt[3] = '{4, 1'b1, 1'b0, 2'b00, 1'b1, 32'h200, 32'hDEADBEEF};
        vt[4] = '{5, 1'b1, 1'b1, 2'b00, 1'b0, 32'h200, 32'hDEADBEEF};
        vt[5] = '{6, 1'b0, 1'b0, 2'b00, 1'b0, 32'h200, 32'hDEADBEEF};

        HRESETn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        stall_n = 0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_htrans", HTRANS, 2'b00);
        chk("reset_hwrite", HWRITE, 0);
        chk("reset_haddr", HADDR, 0);
        chk("reset_hwdata", HWDATA, 0);
        chk("reset_hsize", HSIZE, 3'b010);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // len=1 trace
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h100, 32'h200, 16'd1, 0, 0, 0, dc, nd, nns);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t1_busy_c%0d", vt[i].cyc),   tr[vt[i].cyc].busy,   vt[i].busy);
            chk($sformatf("t1_done_c%0d", vt[i].cyc),   tr[vt[i].cyc].done,   vt[i].done);
            chk($sformatf("t1_htrans_c%0d", vt[i].cyc), tr[vt[i].cyc].htrans, vt[i].htrans);
            chk($sformatf("t1_hwrite_c%0d", vt[i].cyc), tr[vt[i].cyc].hwrite, vt[i].hwrite);
            chk($sformatf("t1_haddr_c%0d", vt[i].cyc),  tr[vt[i].cyc].haddr,  vt[i].haddr);
            chk($sformatf("t1_hwdata_c%0d", vt[i].cyc), tr[vt[i].cyc].hwdata, vt[i].hwdata);
        end
        chk("t1_done_cyc", dc, 5);
        chk("t1_nonseq", nns, 2);
        chk_copy(32'h100, 32'h200, 1, nr, nw);

        // len=4, zero wait
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h0, 32'h1000, 16'd4, 0, 0, 0, dc, nd, nns);
        chk("t2_done_cyc", dc, 17);
        chk("t2_nonseq", nns, 8);
        chk_copy(32'h0, 32'h1000, 4, nr, nw);

        // len=4, 2 wait states per data phase
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h0, 32'h1000, 16'd4, 2, 0, 0, dc, nd, nns);
        chk("t3_done_cyc", dc, 33);
        chk("t3_ndone", nd, 1);
        chk_copy(32'h0, 32'h1000, 4, nr, nw);

        // len=0
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h40, 32'h80, 16'd0, 0, 0, 0, dc, nd, nns);
        chk("t4_done_cyc", dc, 1);
        chk("t4_nonseq", nns, 0);
        chk("t4_busy_c1", tr[1].busy, 1);
        chk("t4_busy_c2", tr[2].busy, 0);
        chk_copy(32'h40, 32'h80, 0, nr, nw);

        // unaligned source/destination are word-aligned
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h103, 32'h302, 16'd1, 0, 0, 0, dc, nd, nns);
        chk("t5_done_cyc", dc, 5);
        chk_copy(32'h100, 32'h300, 1, nr, nw);

        // start while busy is ignored
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h40, 32'h2000, 16'd4, 0, 6, 0, dc, nd, nns);
        chk("t6_done_cyc", dc, 17);
        chk("t6_ndone", nd, 1);
        repeat (6) @(negedge HCLK);
        chk("t6_idle_busy", busy, 0);
        chk_copy(32'h40, 32'h2000, 4, nr, nw);

        // pointer wrap
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'hFFFF_FFFC, 32'h500, 16'd2, 0, 0, 0, dc, nd, nns);
        chk("t7_done_cyc", dc, 9);
        chk_copy(32'hFFFF_FFFC, 32'h500, 2, nr, nw);

        // reset during WR_D of word 1, then a fresh copy
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h600, 32'h700, 16'd2, 0, 0, 8, dc, nd, nns);
        chk("t8_writes_before_rst", wa_log.size() - nw, 1);
        @(negedge HCLK);
        chk("t8_idle_busy", busy, 0);
        chk("t8_idle_htrans", HTRANS, 2'b00);
        nr = rd_log.size(); nw = wa_log.size();
        run_copy(32'h100, 32'h900, 16'd1, 0, 0, 0, dc, nd, nns);
        chk("t8_done_cyc", dc, 5);
        chk_copy(32'h100, 32'h900, 1, nr, nw);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ahb_copy_master.md
# ahb_copy_master

AHB-Lite initiator that copies a block of 32-bit words from a source address to a destination address using single, non-burst transfers. It drives the same bus that the on-chip SRAM and test memories respond on, and is the bus master the testbench and system use to move data between memories. Each word costs one read transfer followed by one write transfer. Address and data phases are correctly pipelined, and wait states are honoured via HREADY.

## Interface
Parameters:
- LEN_W, 16, width of the word-count input; max copy length is 2^LEN_W-1 words.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low; the block has one clock.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_addr  in  `AHB_ADDR_WIDTH`  source byte address; bits [1:0] are ignored and treated as 0.
- dst_addr  in  `AHB_ADDR_WIDTH`  destination byte address; bits [1:0] are ignored and treated as 0.
- len  in  LEN_W  number of words to copy.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the copy completes.
- HADDR  out  `AHB_ADDR_WIDTH`  transfer address.
- HTRANS  out  2  transfer type: 2'b00 IDLE or 2'b10 NONSEQ only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  fixed 3'b010 (word).
- HWDATA  out  `AHB_DATA_WIDTH`  write data.
- HRDATA  in  `AHB_DATA_WIDTH`  read data.
- HREADY  in  1  transfer complete / slave ready.

## Operation
- start is sampled in IDLE. On start=1, the block latches:
  - src pointer = {src_addr[31:2],2'b00}
  - dst pointer = {dst_addr[31:2],2'b00}
  - remaining = len
- States and transitions:
  - IDLE: start && len!=0 -> RD_A. start && len==0 -> DONE; no bus transfer is issued.
  - RD_A: drive HTRANS=NONSEQ, HWRITE=0, HADDR=src pointer. When HREADY=1 -> RD_D.
  - RD_D: drive HTRANS=IDLE. When HREADY=1, capture HRDATA into the data buffer -> WR_A.
  - WR_A: drive HTRANS=NONSEQ, HWRITE=1, HADDR=dst pointer. When HREADY=1 -> WR_D.
  - WR_D: drive HTRANS=IDLE and HWDATA=buffer. When HREADY=1, decrement remaining and add 4 to both pointers. Then go to DONE if remaining was 1, else RD_A.
  - DONE: done=1 for this one cycle -> IDLE.
- HADDR, HWRITE and HTRANS hold stable while HREADY=0 in an address-phase state.
- HWDATA holds stable throughout WR_D, including wait states.
- Pointers wrap modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000). There is no error and no stall on wrap.
- start asserted while busy=1 is ignored. The latched parameters are not disturbed.
- src_addr, dst_addr and len may change after the start cycle without effect.
- HRESP is not used; every transfer is assumed OKAY.
- Overlapping regions are copied in ascending address order without correction.

## Timing
- Reset values: busy=0, done=0, HTRANS=2'b00, HWRITE=0, HADDR=0, HWDATA=0, HSIZE=3'b010. State is IDLE; pointers, remaining and buffer are 0.
- All outputs are registered, or decoded from registered state only. There is no combinational path from HRDATA or HREADY to any output.
- Zero-wait-state timing, with start high in cycle 0:
  - RD_A occupies cycle 1.
  - Word k occupies cycles 4k+1 .. 4k+4.
  - done is high in cycle 4*len+1; busy is low again from cycle 4*len+2.
- Each HREADY=0 cycle extends the current state by exactly one cycle.
- len=0: done is high in cycle 1, busy is high in cycle 1 only, and HTRANS stays IDLE throughout.
- Reset asserted mid-copy returns all outputs to their reset values immediately (asynchronously). After release the block sits in IDLE with no pending transfer.

## Test plan
- len=1, src=0x100, dst=0x200, mem[0x100]=0xDEADBEEF, zero wait states -> exactly two NONSEQ transfers: read 0x100 in cycle 1, write 0x200 in cycle 3. HWDATA=0xDEADBEEF in cycle 4, done in cycle 5, mem[0x200]=0xDEADBEEF.
- len=4, src=0x0, dst=0x1000, slave HREADY tied to 1 -> done in cycle 17. The read address sequence is 0x0,0x4,0x8,0xC; the write sequence is 0x1000..0x100C; all four words match.
- Same as above, but the slave drops HREADY for 2 cycles in every data phase -> done in cycle 33, identical data, and HADDR/HWDATA stable during each stall.
- len=0 -> done in cycle 1, no NONSEQ ever observed. Separately, src=0x103 with len=1 -> read address 0x100.
- start pulsed again while busy with different parameters -> ignored; the original copy completes unaltered with a single done pulse.
- Addresses and buffer edge cases:
  - src=0xFFFFFFFC, len=2 -> reads 0xFFFFFFFC then 0x00000000.
  - HRESETn pulled low during WR_D of word 1 -> busy=0 and HTRANS=IDLE immediately; a fresh start afterwards completes normally.
